// File: rtl/touch_adc_control.sv
// touch_adc_control: serial controller for an ADS7843-class 12-bit touch-screen ADC.
// A touch starts an X frame followed by a Y frame, 24 DCLK periods each. Both
// coordinates are then published together on the parallel outputs.
module touch_adc_control #(
  parameter int unsigned DCLK_HALF  = 8,
  parameter logic [7:0]  CMD_X      = 8'h92,
  parameter logic [7:0]  CMD_Y      = 8'hD2,
  parameter int unsigned GAP_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ADC_PENIRQ_n,
  input  logic        ADC_DOUT,
  input  logic        ADC_BUSY,
  output logic        ADC_DCLK,
  output logic        ADC_DIN,
  output logic        SCEN,
  output logic [11:0] X_COORD,
  output logic [11:0] Y_COORD
);

  // One counter serves both the DCLK half-period timer and the inter-pair gap timer.
  localparam int unsigned CntMax = (DCLK_HALF > GAP_CYCLES) ? DCLK_HALF : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftX,
    StShiftY,
    StLatch,
    StGap
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            half_q;    // 0: low half of the DCLK period, 1: high half
  logic [4:0]      period_q;  // DCLK period within the frame, 1..24
  logic [11:0]     sx_q;
  logic [11:0]     sy_q;
  logic            dclk_q;
  logic            din_q;
  logic            scen_q;
  logic [11:0]     x_q;
  logic [11:0]     y_q;

  logic            half_done;
  logic            gap_done;
  logic            sample_win;
  logic [7:0]      cur_cmd;
  logic [2:0]      bit_idx;
  logic            unused_busy;

  // BUSY is informational; sequencing is purely time-based.
  assign unused_busy = ADC_BUSY;

  assign half_done  = (cnt_q == CntW'(DCLK_HALF - 1));
  assign gap_done   = (cnt_q == CntW'(GAP_CYCLES - 1));
  assign sample_win = (period_q >= 5'd10) && (period_q <= 5'd21);
  assign cur_cmd    = (state_q == StShiftX) ? CMD_X : CMD_Y;
  // Bit to present for the period following period_q; only meaningful for periods 1..7.
  assign bit_idx    = 3'(5'd7 - period_q);

  assign ADC_DCLK = dclk_q;
  assign ADC_DIN  = din_q;
  assign SCEN     = scen_q;
  assign X_COORD  = x_q;
  assign Y_COORD  = y_q;

  // Sequencer: state, timers, serial shifting and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      half_q   <= 1'b0;
      period_q <= 5'd0;
      sx_q     <= 12'h000;
      sy_q     <= 12'h000;
      dclk_q   <= 1'b0;
      din_q    <= 1'b0;
      scen_q   <= 1'b1;
      x_q      <= 12'h000;
      y_q      <= 12'h000;
    end else begin
      case (state_q)
        StIdle: begin
          dclk_q <= 1'b0;
          din_q  <= 1'b0;
          scen_q <= 1'b1;
          cnt_q  <= '0;
          if (!ADC_PENIRQ_n) begin
            state_q <= StSetup;
            scen_q  <= 1'b0;
            din_q   <= CMD_X[7];
          end
        end
        StSetup: begin
          if (half_done) begin
            state_q  <= StShiftX;
            cnt_q    <= '0;
            half_q   <= 1'b0;
            period_q <= 5'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShiftX, StShiftY: begin
          if (!half_done) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            if (!half_q) begin
              // Mid-period: DCLK rises, DOUT captured in the data window.
              half_q <= 1'b1;
              dclk_q <= 1'b1;
              if (sample_win) begin
                if (state_q == StShiftX) sx_q <= {sx_q[10:0], ADC_DOUT};
                else                     sy_q <= {sy_q[10:0], ADC_DOUT};
              end
            end else begin
              // Period end: DCLK falls, DIN advances while DCLK is low.
              half_q <= 1'b0;
              dclk_q <= 1'b0;
              if (period_q == 5'd24) begin
                period_q <= 5'd1;
                if (state_q == StShiftX) begin
                  state_q <= StShiftY;
                  din_q   <= CMD_Y[7];
                end else begin
                  state_q <= StLatch;
                  din_q   <= 1'b0;
                end
              end else begin
                period_q <= period_q + 5'd1;
                din_q    <= (period_q < 5'd8) ? cur_cmd[bit_idx] : 1'b0;
              end
            end
          end
        end
        StLatch: begin
          scen_q  <= 1'b1;
          x_q     <= sx_q;
          y_q     <= sy_q;
          state_q <= StGap;
          cnt_q   <= '0;
        end
        StGap: begin
          if (gap_done) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_adc_control.sv
// Directed bench for touch_adc_control with a behavioural ADC serial model.
module tb_touch_adc_control;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ADC_PENIRQ_n = 1'b1;
  logic        ADC_DOUT = 1'b0;
  logic        ADC_BUSY = 1'b0;
  logic        ADC_DCLK;
  logic        ADC_DIN;
  logic        SCEN;
  logic [11:0] X_COORD;
  logic [11:0] Y_COORD;

  int checks = 0;
  int passes = 0;

  logic [11:0] x_val = 12'h000;
  logic [11:0] y_val = 12'h000;
  int          rise_cnt = 0;
  logic [7:0]  cmd_cap [2];

  touch_adc_control dut (
    .CLK          (CLK),
    .RST          (RST),
    .ADC_PENIRQ_n (ADC_PENIRQ_n),
    .ADC_DOUT     (ADC_DOUT),
    .ADC_BUSY     (ADC_BUSY),
    .ADC_DCLK     (ADC_DCLK),
    .ADC_DIN      (ADC_DIN),
    .SCEN         (SCEN),
    .X_COORD      (X_COORD),
    .Y_COORD      (Y_COORD)
  );

  always #5 CLK = ~CLK;

  // ADC model: counts DCLK rises in a pair, records DIN command bits, and sets
  // DOUT for the next period (data bits MSB first in periods 10..21).
  always @(posedge ADC_DCLK or negedge SCEN) begin
    int f, per, nf, np;
    logic [11:0] v;
    if (ADC_DCLK) begin
      rise_cnt = rise_cnt + 1;
      f   = (rise_cnt - 1) / 24;
      per = (rise_cnt - 1) % 24 + 1;
      if (per <= 8 && f < 2) cmd_cap[f][8-per] = ADC_DIN;
      nf = rise_cnt / 24;
      np = rise_cnt % 24 + 1;
      v  = (nf == 0) ? x_val : y_val;
      ADC_DOUT = (np >= 10 && np <= 21) ? v[21-np] : 1'b0;
    end else begin
      rise_cnt = 0;
      ADC_DOUT = 1'b0;
    end
  end

  // Runs one touch; lat is the CLK count from SETUP start to SCEN rising.
  task automatic run_pair(input logic [11:0] xv, input logic [11:0] yv, input int release_at,
                          output bit to, output int lat);
    to = 1'b0;
    lat = 0;
    x_val = xv;
    y_val = yv;
    ADC_PENIRQ_n = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (SCEN === 1'b0) break;
    end
    if (SCEN !== 1'b0) begin
      to = 1'b1;
      ADC_PENIRQ_n = 1'b1;
      return;
    end
    if (release_at == 0) ADC_PENIRQ_n = 1'b1;
    for (int n = 1; n <= 1500; n++) begin
      @(negedge CLK);
      if (n == release_at) ADC_PENIRQ_n = 1'b1;
      if (SCEN === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) to = 1'b1;
    ADC_PENIRQ_n = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    ADC_PENIRQ_n = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (SCEN !== 1'b1) $display("FAIL reset_scen got %b want 1", SCEN); else passes++;
    checks++; if (ADC_DCLK !== 1'b0) $display("FAIL reset_dclk got %b want 0", ADC_DCLK); else passes++;
    checks++; if (ADC_DIN !== 1'b0) $display("FAIL reset_din got %b want 0", ADC_DIN); else passes++;
    checks++; if (X_COORD !== 12'h000) $display("FAIL reset_x got %h want 000", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'h000) $display("FAIL reset_y got %h want 000", Y_COORD); else passes++;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_single();
    bit to;
    int lat;
    run_pair(12'h92E, 12'hB16, 0, to, lat);
    checks++; if (to !== 1'b0) $display("FAIL single_timeout got %b want 0", to); else passes++;
    checks++; if (lat != 777) $display("FAIL single_latency got %0d want 777", lat); else passes++;
    checks++; if (X_COORD !== 12'h92E) $display("FAIL single_x got %h want 92e", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'hB16) $display("FAIL single_y got %h want b16", Y_COORD); else passes++;
    checks++; if (cmd_cap[0] !== 8'h92) $display("FAIL single_cmd_x got %h want 92", cmd_cap[0]); else passes++;
    checks++; if (cmd_cap[1] !== 8'hD2) $display("FAIL single_cmd_y got %h want d2", cmd_cap[1]); else passes++;
    checks++; if (rise_cnt != 48) $display("FAIL single_rises got %0d want 48", rise_cnt); else passes++;
  endtask

  task automatic test_reset_midframe();
    bit to;
    int lat;
    ADC_PENIRQ_n = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (SCEN === 1'b0) break;
    end
    ADC_PENIRQ_n = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (rise_cnt == 12) break;
    end
    checks++; if (rise_cnt != 12) $display("FAIL mid_reach_p12 got %0d want 12", rise_cnt); else passes++;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (SCEN !== 1'b1) $display("FAIL mid_scen got %b want 1", SCEN); else passes++;
    checks++; if (ADC_DCLK !== 1'b0) $display("FAIL mid_dclk got %b want 0", ADC_DCLK); else passes++;
    checks++; if (ADC_DIN !== 1'b0) $display("FAIL mid_din got %b want 0", ADC_DIN); else passes++;
    checks++; if (X_COORD !== 12'h000) $display("FAIL mid_x got %h want 000", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'h000) $display("FAIL mid_y got %h want 000", Y_COORD); else passes++;
    RST = 1'b0;
    @(negedge CLK);
    run_pair(12'h5A3, 12'h3C7, 0, to, lat);
    checks++; if (lat != 777) $display("FAIL mid_clean_latency got %0d want 777", lat); else passes++;
    checks++; if (X_COORD !== 12'h5A3) $display("FAIL mid_clean_x got %h want 5a3", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'h3C7) $display("FAIL mid_clean_y got %h want 3c7", Y_COORD); else passes++;
    checks++; if (rise_cnt != 48) $display("FAIL mid_clean_rises got %0d want 48", rise_cnt); else passes++;
  endtask

  task automatic test_back_to_back();
    bit to;
    int lat;
    for (int p = 0; p < 3; p++) begin
      run_pair(12'hA15, 12'h1B9, 0, to, lat);
      checks++; if (X_COORD !== 12'hA15) $display("FAIL b2b_x[%0d] got %h want a15", p, X_COORD); else passes++;
      checks++; if (Y_COORD !== 12'h1B9) $display("FAIL b2b_y[%0d] got %h want 1b9", p, Y_COORD); else passes++;
      checks++; if (rise_cnt != 48) $display("FAIL b2b_rises[%0d] got %0d want 48", p, rise_cnt); else passes++;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic test_random();
    bit to;
    int lat;
    logic [11:0] xv, yv;
    for (int p = 0; p < 3; p++) begin
      xv = 12'($urandom_range(0, 4095));
      yv = 12'($urandom_range(0, 4095));
      run_pair(xv, yv, 0, to, lat);
      checks++; if (X_COORD !== xv) $display("FAIL rand_x[%0d] got %h want %h", p, X_COORD, xv); else passes++;
      checks++; if (Y_COORD !== yv) $display("FAIL rand_y[%0d] got %h want %h", p, Y_COORD, yv); else passes++;
    end
  endtask

  task automatic test_extreme();
    bit to;
    int lat;
    run_pair(12'hFFF, 12'h000, 0, to, lat);
    checks++; if (X_COORD !== 12'hFFF) $display("FAIL ext1_x got %h want fff", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'h000) $display("FAIL ext1_y got %h want 000", Y_COORD); else passes++;
    run_pair(12'h000, 12'hFFF, 0, to, lat);
    checks++; if (X_COORD !== 12'h000) $display("FAIL ext2_x got %h want 000", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'hFFF) $display("FAIL ext2_y got %h want fff", Y_COORD); else passes++;
  endtask

  task automatic test_idle_release();
    bit to;
    int lat;
    int bad;
    bad = 0;
    ADC_PENIRQ_n = 1'b1;
    repeat (100) @(negedge CLK);  // let any running gap finish
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (SCEN !== 1'b1 || ADC_DCLK !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL idle_quiet got %0d bad cycles want 0", bad); else passes++;
    run_pair(12'hC3A, 12'h25F, 200, to, lat);
    checks++; if (lat != 777) $display("FAIL release_latency got %0d want 777", lat); else passes++;
    checks++; if (X_COORD !== 12'hC3A) $display("FAIL release_x got %h want c3a", X_COORD); else passes++;
    checks++; if (Y_COORD !== 12'h25F) $display("FAIL release_y got %h want 25f", Y_COORD); else passes++;
    repeat (300) @(negedge CLK);
    checks++; if (X_COORD !== 12'hC3A) $display("FAIL hold_x got %h want c3a", X_COORD); else passes++;
    checks++; if (SCEN !== 1'b1) $display("FAIL hold_scen got %b want 1", SCEN); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    test_extreme();
    test_idle_release();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
